// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
//   Buffers host read/write requests in a DEPTH-entry FIFO and issues them
//   one at a time to a single-port static memory. Each access is a one-cycle
//   mem_valid pulse. The controller then waits for mem_ready and returns a
//   one-cycle response: read data, or a write-done indication.
//
//   Optional build macro: MEM_REQ_TIMEOUT_EN
//     When defined, an access whose mem_ready has not arrived after TIMEOUT
//     WAIT cycles is aborted with resp_err = 1. When undefined, WAIT waits
//     indefinitely and resp_err is constant 0.
//
//   Ports
//     clk, rst            clock (rising edge), async active-high reset
//     req_valid/req_ready host request handshake (req_ready = !full)
//     req_wr_rd/addr/wdata request payload (1 = write)
//     resp_valid          one-cycle completion pulse, no backpressure
//     resp_wr/rdata/err   completed op type, read data, timeout flag
//     mem_valid/wr_rd/addr/wdata  registered memory request
//     mem_rdata/mem_ready memory response
module mem_req_ctrl #(
   parameter int DEPTH   = 4,
   parameter int AW      = 10,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr_rd,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic          resp_wr,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic          mem_valid,
   output logic          mem_wr_rd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic          wr_rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   req_t          fifo [DEPTH];
   req_t          head;
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   count;
   logic          full, empty, push, pop;

   state_t state, state_n;
   logic   done, abort, fin;

   assign full      = (count == (PW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign head      = fifo[rptr];

   // ---------------- request FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) fifo[wptr] <= '{wr_rd: req_wr_rd, addr: req_addr, wdata: req_wdata};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;   // DEPTH is a power of 2: wraps naturally
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- optional timeout ----------------
`ifdef MEM_REQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [TW-1:0] tmo_cnt;

   // Fires on the TIMEOUT-th consecutive WAIT cycle without mem_ready.
   assign abort = (state == WAIT) && !mem_ready && (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt  <= '0;
         resp_err <= 1'b0;
      end else begin
         resp_err <= abort;
         if (state != WAIT)  tmo_cnt <= '0;   // WAIT is only entered from ISSUE
         else if (!mem_ready) tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign abort    = 1'b0;
   assign resp_err = 1'b0;
`endif

   // ---------------- control FSM ----------------
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: state_n = WAIT;
         WAIT: begin
            done = mem_ready;
            if (mem_ready || abort) begin
               // Chain straight into the next access for 2-cycle throughput.
               if (!empty) begin
                  pop     = 1'b1;
                  state_n = ISSUE;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign fin = done || abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_valid  <= 1'b0;
         mem_wr_rd  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_wr    <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state     <= state_n;
         // Every pop enters ISSUE, so the strobe is exactly one cycle wide.
         mem_valid <= pop;
         if (pop) begin
            mem_wr_rd <= head.wr_rd;
            mem_addr  <= head.addr;
            mem_wdata <= head.wdata;
         end
         resp_valid <= fin;
         resp_wr    <= fin && mem_wr_rd;
         resp_rdata <= (done && !mem_wr_rd) ? mem_rdata : '0;
      end
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr_rd;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_wr, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_wr_rd, mem_ready;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   mem_req_ctrl #(.DEPTH(4), .AW(10), .DW(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr_rd(req_wr_rd),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_resp = 0;
   int resp_cyc [$];

   typedef struct {
      logic        wr;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t expq [$];

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   // Samples valid at an edge, answers with ready on the next cycle unless
   // stalled; a stalled access stays pending until stall drops.
   logic        stall = 1'b0;
   logic        pend;
   logic [31:0] ram [1024];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend      <= 1'b0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= 1'b0;
         if ((pend || mem_valid) && !stall) begin
            mem_ready <= 1'b1;
            mem_rdata <= mem_wr_rd ? 32'h0 : ram[mem_addr];
            if (mem_wr_rd) ram[mem_addr] <= mem_wdata;
            pend <= 1'b0;
         end else begin
            pend <= pend || mem_valid;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic prev_mv = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_mv = 1'b0;
      end else begin
         if (mem_valid) begin
            checks++;
            if (prev_mv) begin
               errors++;
               $display("FAIL mem_valid_pulse got 2+ cycles want 1 cycle (cyc %0d)", cyc);
            end
         end
         prev_mv = mem_valid;
         if (resp_valid) begin
            n_resp++;
            resp_cyc.push_back(cyc);
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp got wr=%0b rdata=%h err=%0b want none",
                        resp_wr, resp_rdata, resp_err);
            end else begin
               exp_t e;
               e = expq.pop_front();
               if (resp_wr !== e.wr || resp_rdata !== e.rdata || resp_err !== e.err) begin
                  errors++;
                  $display("FAIL resp got wr=%0b rdata=%h err=%0b want wr=%0b rdata=%h err=%0b",
                           resp_wr, resp_rdata, resp_err, e.wr, e.rdata, e.err);
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic wr, input logic [9:0] a, input logic [31:0] d,
                       input logic [31:0] e_rdata, input logic e_err);
      int n;
      exp_t e;
      req_valid = 1'b1; req_wr_rd = wr; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL push_ready got req_ready=0 for 50 cycles want 1");
      end else begin
         e.wr = wr; e.rdata = e_rdata; e.err = e_err;
         expq.push_back(e);
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int base, r0;
      rst = 1'b1; req_valid = 1'b0; req_wr_rd = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_mem_valid", 32'(mem_valid), 32'd0);
      chk("idle_resp_err", 32'(resp_err), 32'd0);

      // Write then read back one location.
      push(1'b1, 10'h005, 32'hDEADBEEF, 32'h0, 1'b0);
      push(1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 1'b0);
      wait_idle();

      // Latency of a single read accepted at edge N.
      begin
         exp_t e;
         req_valid = 1'b1; req_wr_rd = 1'b0; req_addr = 10'h005;
         e.wr = 1'b0; e.rdata = 32'hDEADBEEF; e.err = 1'b0;
         expq.push_back(e);
         @(negedge clk);                    // after N
         req_valid = 1'b0;
         chk("lat_n_mem_valid", 32'(mem_valid), 32'd0);
         @(negedge clk);                    // after N+1
         chk("lat_n1_mem_valid", 32'(mem_valid), 32'd1);
         chk("lat_n1_mem_addr", 32'(mem_addr), 32'h005);
         chk("lat_n1_mem_wr_rd", 32'(mem_wr_rd), 32'd0);
         @(negedge clk);                    // after N+2
         chk("lat_n2_mem_valid", 32'(mem_valid), 32'd0);
         chk("lat_n2_resp_valid", 32'(resp_valid), 32'd0);
         @(negedge clk);                    // after N+3
         chk("lat_n3_resp_valid", 32'(resp_valid), 32'd1);
         wait_idle();
      end

      // Fill the FIFO behind a stalled memory, then drain at full rate.
      stall = 1'b1;
      push(1'b1, 10'h000, 32'h11110000, 32'h0, 1'b0);
      push(1'b1, 10'h001, 32'h22221111, 32'h0, 1'b0);
      push(1'b1, 10'h002, 32'h33332222, 32'h0, 1'b0);
      push(1'b1, 10'h003, 32'h44443333, 32'h0, 1'b0);
      push(1'b0, 10'h000, 32'h0, 32'h11110000, 1'b0);
      chk("full_req_ready", 32'(req_ready), 32'd0);
      chk("full_count", 32'(dut.count), 32'd4);
      base = resp_cyc.size();
      stall = 1'b0;
      push(1'b0, 10'h001, 32'h0, 32'h22221111, 1'b0);
      push(1'b0, 10'h002, 32'h0, 32'h33332222, 1'b0);
      push(1'b0, 10'h003, 32'h0, 32'h44443333, 1'b0);
      wait_idle();
      chk("burst_resp_count", 32'(resp_cyc.size() - base), 32'd8);
      if (resp_cyc.size() - base == 8)
         for (int i = 0; i < 7; i++)
            chk("burst_spacing", 32'(resp_cyc[base+i+1] - resp_cyc[base+i]), 32'd2);

      // Push and pop on the same edge at count 2, across the pointer wrap.
      stall = 1'b1;
      push(1'b1, 10'h3F0, 32'hA5A50001, 32'h0, 1'b0);
      push(1'b1, 10'h3F1, 32'hA5A50002, 32'h0, 1'b0);
      push(1'b0, 10'h3F0, 32'h0, 32'hA5A50001, 1'b0);
      chk("pp_count_before", 32'(dut.count), 32'd2);
      stall = 1'b0;                         // memory answers at the next edge E
      @(negedge clk);                       // after E: ready is high
      begin
         exp_t e;
         req_valid = 1'b1; req_wr_rd = 1'b0; req_addr = 10'h3F1;
         e.wr = 1'b0; e.rdata = 32'hA5A50002; e.err = 1'b0;
         expq.push_back(e);
      end
      @(negedge clk);                       // after E+1: pop and push together
      req_valid = 1'b0;
      chk("pp_count_after", 32'(dut.count), 32'd2);
      wait_idle();

      // Memory that never answers.
      stall = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
      push(1'b0, 10'h005, 32'h0, 32'h0, 1'b1);
      wait_idle();
      stall = 1'b0;
      repeat (4) @(negedge clk);
`else
      push(1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 1'b0);
      r0 = n_resp;
      repeat (40) @(negedge clk);
      chk("hang_no_resp", 32'(n_resp - r0), 32'd0);
      chk("hang_mem_valid", 32'(mem_valid), 32'd0);
      stall = 1'b0;
      wait_idle();
`endif

      // Asynchronous reset in the middle of WAIT.
      stall = 1'b1;
      push(1'b1, 10'h010, 32'h12345678, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("mid_wait_addr", 32'(mem_addr), 32'h010);
      #2 rst = 1'b1;
      #1;
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_mem_wr_rd", 32'(mem_wr_rd), 32'd0);
      chk("arst_mem_addr", 32'(mem_addr), 32'd0);
      chk("arst_mem_wdata", mem_wdata, 32'd0);
      chk("arst_resp_valid", 32'(resp_valid), 32'd0);
      expq.delete();
      r0 = n_resp;
      @(negedge clk);
      stall = 1'b0;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("arst_no_resp", 32'(n_resp - r0), 32'd0);
      push(1'b0, 10'h005, 32'h0, 32'hDEADBEEF, 1'b0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
Request controller that sits directly upstream of the single-port static memory (valid/ready, wr_rd, 10-bit addr, 32-bit data). It buffers host read/write requests in a small FIFO and issues them to the memory one at a time as single-cycle valid pulses. It waits for the memory's ready and returns read data, or a write-done indication, to the host.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
AW, 10, address width
DW, 32, data width
TIMEOUT, 15, max WAIT cycles before abort (used only with MEM_REQ_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  host request present
req_ready  out  1  FIFO can accept (= !full)
req_wr_rd  in  1  1 = write, 0 = read
req_addr  in  AW  request address
req_wdata  in  DW  write data
resp_valid  out  1  one-cycle completion pulse
resp_wr  out  1  completed op was a write
resp_rdata  out  DW  read data (0 for writes and errors)
resp_err  out  1  timeout abort flag (tied 0 without macro)
mem_valid  out  1  access strobe to memory
mem_wr_rd  out  1  to memory wr_rd
mem_addr  out  AW  to memory addr
mem_wdata  out  DW  to memory wdata
mem_rdata  in  DW  from memory rdata
mem_ready  in  1  from memory ready

Behaviour:
- Reset (async, active-high): FIFO pointers and count = 0; state = IDLE; all outputs 0 except req_ready = 1. An in-flight access is dropped with no response.
- FIFO: entry = {wr_rd, addr, wdata}. Push when req_valid & req_ready. Pop only by the FSM, and only when non-empty; no bypass. Push and pop in the same cycle are allowed and leave the count unchanged. req_ready is combinational !full.
- mem_* outputs are registered and stay stable from ISSUE until the next load.
- Memory contract: memory samples valid each edge and raises ready on the following edge. mem_valid is therefore a single-cycle pulse; holding it would repeat the access.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty, pop head into mem_* regs and go to ISSUE; otherwise stay.
  - ISSUE: mem_valid = 1 for exactly one cycle, then go to WAIT.
  - WAIT: mem_valid = 0.
    - On mem_ready = 1: resp_valid = 1 for one cycle. resp_wr = mem_wr_rd. resp_rdata = mem_rdata for reads, 0 for writes. resp_err = 0.
    - Then, if FIFO non-empty, pop the next entry and go straight to ISSUE; otherwise go to IDLE.
    - mem_ready while in IDLE or ISSUE is ignored.
- Latency: a request pushed at edge N drives mem_valid high after N+1 and low after N+2, and produces resp_valid after edge N+3.
- Throughput: back-to-back accesses complete every 2 cycles.
- A full FIFO deasserts req_ready. The host must hold its request; there is no drop and no overwrite.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- resp_valid is a pulse with no backpressure; the host must accept it.

Optional Feature:
MEM_REQ_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without mem_ready. On reaching TIMEOUT, the access aborts: resp_valid = 1, resp_err = 1, resp_rdata = 0, resp_wr = mem_wr_rd. The FSM then follows the normal WAIT exit (next ISSUE or IDLE).
- Not defined: WAIT waits indefinitely, no counter logic is built, and resp_err is constant 0.

Test Plan:
- Reset then idle: req_ready = 1, mem_valid = 0, resp_valid = 0. Assert rst mid-WAIT: all outputs clear immediately with no clock edge, and no response is issued.
- Write addr 0x005, data 0xDEADBEEF, then read addr 0x005 -> first response resp_wr = 1, resp_rdata = 0; second response resp_wr = 0, resp_rdata = 0xDEADBEEF. mem_valid is high for exactly 1 cycle per access.
- Latency check: single read pushed at edge N -> mem_valid high only between edges N+1 and N+2; resp_valid high after edge N+3.
- Push 5 requests back-to-back with DEPTH = 4 and the memory stalled -> req_ready drops at count 4. All 5 complete in order, and writes to addrs 0x000..0x003 followed by reads return matching data, with 2-cycle spacing.
- Simultaneous push and pop while count = 2 -> count stays 2 and order is preserved across a pointer wrap.
- With MEM_REQ_TIMEOUT_EN and mem_ready held 0: after 15 WAIT cycles, resp_valid = 1, resp_err = 1, resp_rdata = 0, and the next queued request is issued. Without the macro, no response and the FSM stays in WAIT.
